// File: rtl/cam_pkg.sv
// Shared constants for the camera capture front-end: FSM encoding, default frame
// geometry, RGB565 field positions and the saturating coordinate increment.
package cam_pkg;

    localparam logic [1:0] WAIT_VSYNC = 2'd0;
    localparam logic [1:0] WAIT_FRAME = 2'd1;
    localparam logic [1:0] ACTIVE     = 2'd2;

    localparam int H_PIXELS_DEFAULT = 640;
    localparam int V_LINES_DEFAULT  = 480;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    localparam logic [9:0] COORD_MAX = 10'd1023;

    // Coordinates stick at their maximum instead of wrapping back into range.
    function automatic logic [9:0] sat_inc10(input logic [9:0] value);
        if (value == COORD_MAX) begin
            return value;
        end else begin
            return value + 10'd1;
        end
    endfunction

endpackage

// File: rtl/camera_capture_if.sv
// Bundle of the raw camera bus and the assembled-pixel outputs of camera_capture.
interface camera_capture_if;

    logic        cam_pclk;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic [15:0] camera_pixel;
    logic        pixel_valid;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        line_error;

    modport slave (
        input  cam_pclk, cam_vsync, cam_href, cam_data,
        output camera_pixel, pixel_valid, pixel_x, pixel_y,
               frame_done, frame_count, line_error
    );

    modport master (
        output cam_pclk, cam_vsync, cam_href, cam_data,
        input  camera_pixel, pixel_valid, pixel_x, pixel_y,
               frame_done, frame_count, line_error
    );

endinterface

// File: rtl/cam_sync_edge.sv
// Multi-flop synchroniser for one asynchronous bit, with rise/fall detection
// taken from the synchronised level and one extra history flop.
module cam_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Synchroniser chain plus the history flop used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{1'b0}};
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = chain[STAGES-1] & ~prev;
    assign fall  = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/camera_capture.sv
// Oversamples an 8-bit parallel camera bus and assembles byte pairs into RGB565
// pixels with coordinates, frame counting and a sticky line error flag.
module camera_capture
    import cam_pkg::*;
#(
    parameter int H_PIXELS    = H_PIXELS_DEFAULT,
    parameter int V_LINES     = V_LINES_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             reset,
    camera_capture_if.slave  bus
);

    localparam logic [10:0] H_LIMIT = 11'(H_PIXELS);
    localparam logic [10:0] V_LIMIT = 11'(V_LINES);

    logic [SYNC_STAGES-1:0][7:0] data_chain;
    logic [7:0]  data;
    logic        pclk_level;
    logic        pclk_rise;
    logic        pclk_fall;
    logic        href_level;
    logic        href_rise;
    logic        href_fall;
    logic        vsync_level;
    logic        vsync_rise;
    logic        vsync_fall;
    logic        unused_edges;

    logic [1:0]  state;
    logic        phase_lo;
    logic [7:0]  hi_byte;
    logic [9:0]  column;
    logic [9:0]  row;
    logic        line_has_byte;
    logic        frame_has_pixel;
    logic        in_range;

    logic [15:0] cur_pixel;
    logic        valid_pulse;
    logic [9:0]  cur_x;
    logic [9:0]  cur_y;
    logic        done_pulse;
    logic [7:0]  frames;
    logic        err_flag;

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_pclk_sync (
        .clk(CLK), .reset(reset), .din(bus.cam_pclk),
        .level(pclk_level), .rise(pclk_rise), .fall(pclk_fall)
    );

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_href_sync (
        .clk(CLK), .reset(reset), .din(bus.cam_href),
        .level(href_level), .rise(href_rise), .fall(href_fall)
    );

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_vsync_sync (
        .clk(CLK), .reset(reset), .din(bus.cam_vsync),
        .level(vsync_level), .rise(vsync_rise), .fall(vsync_fall)
    );

    assign unused_edges = pclk_level ^ pclk_fall ^ href_rise;

    // Data bytes take the same number of stages as pclk so they line up with its edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            data_chain <= {SYNC_STAGES{8'h00}};
        end else begin
            data_chain <= {data_chain[SYNC_STAGES-2:0], bus.cam_data};
        end
    end

    assign data     = data_chain[SYNC_STAGES-1];
    assign in_range = ({1'b0, column} < H_LIMIT) && ({1'b0, row} < V_LIMIT);

    // Frame/line FSM, byte pairing, coordinate counters and output registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state           <= WAIT_VSYNC;
            phase_lo        <= 1'b0;
            hi_byte         <= 8'h00;
            column          <= 10'd0;
            row             <= 10'd0;
            line_has_byte   <= 1'b0;
            frame_has_pixel <= 1'b0;
            cur_pixel       <= 16'h0000;
            valid_pulse     <= 1'b0;
            cur_x           <= 10'd0;
            cur_y           <= 10'd0;
            done_pulse      <= 1'b0;
            frames          <= 8'd0;
            err_flag        <= 1'b0;
        end else begin
            valid_pulse <= 1'b0;
            done_pulse  <= 1'b0;
            case (state)
                WAIT_VSYNC: begin
                    if (vsync_level) begin
                        state <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (vsync_fall) begin
                        state           <= ACTIVE;
                        row             <= 10'd0;
                        column          <= 10'd0;
                        phase_lo        <= 1'b0;
                        line_has_byte   <= 1'b0;
                        frame_has_pixel <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // A vsync rise outranks a coincident pclk edge: that byte is lost.
                    if (vsync_rise) begin
                        if (frame_has_pixel) begin
                            done_pulse <= 1'b1;
                            frames     <= frames + 8'd1;
                        end
                        state    <= WAIT_FRAME;
                        phase_lo <= 1'b0;
                    end else if (pclk_rise && href_level) begin
                        line_has_byte <= 1'b1;
                        if (!phase_lo) begin
                            hi_byte  <= data;
                            phase_lo <= 1'b1;
                        end else begin
                            phase_lo        <= 1'b0;
                            frame_has_pixel <= 1'b1;
                            column          <= sat_inc10(column);
                            if (in_range) begin
                                cur_pixel   <= {hi_byte, data};
                                cur_x       <= column;
                                cur_y       <= row;
                                valid_pulse <= 1'b1;
                            end else begin
                                err_flag <= 1'b1;
                            end
                        end
                    end else if (href_fall) begin
                        if (phase_lo) begin
                            err_flag <= 1'b1;
                            hi_byte  <= 8'h00;
                        end
                        phase_lo      <= 1'b0;
                        column        <= 10'd0;
                        line_has_byte <= 1'b0;
                        if (line_has_byte) begin
                            row <= sat_inc10(row);
                        end
                    end
                end
                default: begin
                    state <= WAIT_VSYNC;
                end
            endcase
        end
    end

    assign bus.camera_pixel = cur_pixel;
    assign bus.pixel_valid  = valid_pulse;
    assign bus.pixel_x      = cur_x;
    assign bus.pixel_y      = cur_y;
    assign bus.frame_done   = done_pulse;
    assign bus.frame_count  = frames;
    assign bus.line_error   = err_flag;

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture: a default-geometry instance and a 4-pixel-wide one
// share the same camera stimulus.
module tb_camera_capture;

    logic       CLK = 1'b0;
    logic       reset;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;

    int vectors     = 0;
    int miscompares = 0;

    int          pv_cnt   = 0;
    int          fd_cnt   = 0;
    int          pv_small = 0;
    logic [15:0] pix_log [0:63];
    logic [9:0]  x_log   [0:63];
    logic [9:0]  y_log   [0:63];

    logic [7:0]  t1_bytes [0:11];
    logic [15:0] t1_pix   [0:5];

    int base_pv;
    int base_fd;
    int base_sm;

    always #5 CLK = ~CLK;

    camera_capture_if bus_main ();
    camera_capture_if bus_small ();

    assign bus_main.cam_pclk   = pclk;
    assign bus_main.cam_vsync  = vsync;
    assign bus_main.cam_href   = href;
    assign bus_main.cam_data   = data;
    assign bus_small.cam_pclk  = pclk;
    assign bus_small.cam_vsync = vsync;
    assign bus_small.cam_href  = href;
    assign bus_small.cam_data  = data;

    camera_capture #(.H_PIXELS(640), .V_LINES(480), .SYNC_STAGES(2)) u_main (
        .CLK(CLK), .reset(reset), .bus(bus_main)
    );

    camera_capture #(.H_PIXELS(4), .V_LINES(480), .SYNC_STAGES(2)) u_small (
        .CLK(CLK), .reset(reset), .bus(bus_small)
    );

    // Pulse monitor: logs every emitted pixel of the main instance.
    always @(negedge CLK) begin
        if (bus_main.pixel_valid === 1'b1) begin
            pix_log[pv_cnt % 64] <= bus_main.camera_pixel;
            x_log[pv_cnt % 64]   <= bus_main.pixel_x;
            y_log[pv_cnt % 64]   <= bus_main.pixel_y;
            pv_cnt               <= pv_cnt + 1;
        end
        if (bus_main.frame_done === 1'b1) begin
            fd_cnt <= fd_cnt + 1;
        end
        if (bus_small.pixel_valid === 1'b1) begin
            pv_small <= pv_small + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        data = b;
        pclk = 1'b0;
        tick(4);
        pclk = 1'b1;
        tick(4);
    endtask

    task automatic line_begin();
        href = 1'b1;
        tick(2);
    endtask

    task automatic line_end();
        href = 1'b0;
        tick(8);
    endtask

    task automatic frame_open();
        vsync = 1'b1;
        tick(8);
        vsync = 1'b0;
        tick(8);
    endtask

    task automatic frame_close();
        vsync = 1'b1;
        tick(10);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pixel"},  32'(bus_main.camera_pixel), 32'h0);
        chk({tag, " valid"},  32'(bus_main.pixel_valid),  32'h0);
        chk({tag, " x"},      32'(bus_main.pixel_x),      32'h0);
        chk({tag, " y"},      32'(bus_main.pixel_y),      32'h0);
        chk({tag, " done"},   32'(bus_main.frame_done),   32'h0);
        chk({tag, " count"},  32'(bus_main.frame_count),  32'h0);
        chk({tag, " lerr"},   32'(bus_main.line_error),   32'h0);
    endtask

    initial begin
        t1_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                     8'hDE, 8'hF0, 8'h11, 8'h22, 8'h33, 8'h44};
        t1_pix   = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1122, 16'h3344};

        reset = 1'b1;
        pclk  = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        data  = 8'h00;
        tick(5);
        reset = 1'b0;
        tick(1);
        chk_all_zero("reset");

        // 2 lines x 3 pixels
        frame_open();
        base_pv = pv_cnt;
        base_fd = fd_cnt;
        base_sm = pv_small;
        for (int l = 0; l < 2; l++) begin
            line_begin();
            for (int k = 0; k < 6; k++) send_byte(t1_bytes[l*6+k]);
            line_end();
        end
        chk("t1 pulses", 32'(pv_cnt - base_pv), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("t1 pixel", 32'(pix_log[(base_pv+i)%64]), 32'(t1_pix[i]));
            chk("t1 x",     32'(x_log[(base_pv+i)%64]),   32'(i % 3));
            chk("t1 y",     32'(y_log[(base_pv+i)%64]),   32'(i / 3));
        end
        chk("t1 hold pixel", 32'(bus_main.camera_pixel), 32'h3344);
        chk("t1 lerr", 32'(bus_main.line_error), 32'h0);
        chk("t1 small pulses", 32'(pv_small - base_sm), 32'd6);
        chk("t1 no early done", 32'(fd_cnt - base_fd), 32'd0);
        frame_close();
        chk("t1 done pulses", 32'(fd_cnt - base_fd), 32'd1);
        chk("t1 frame_count", 32'(bus_main.frame_count), 32'd1);

        // 6-pixel line: the 4-wide instance drops the last two
        frame_open();
        base_pv = pv_cnt;
        base_sm = pv_small;
        line_begin();
        for (int k = 0; k < 12; k++) send_byte(8'(8'h40 + k));
        line_end();
        chk("t3 main pulses", 32'(pv_cnt - base_pv), 32'd6);
        chk("t3 main pixel", 32'(bus_main.camera_pixel), 32'h4A4B);
        chk("t3 main x", 32'(bus_main.pixel_x), 32'd5);
        chk("t3 main lerr", 32'(bus_main.line_error), 32'h0);
        chk("t3 small pulses", 32'(pv_small - base_sm), 32'd4);
        chk("t3 small pixel", 32'(bus_small.camera_pixel), 32'h4647);
        chk("t3 small x", 32'(bus_small.pixel_x), 32'd3);
        chk("t3 small lerr", 32'(bus_small.line_error), 32'h1);
        frame_close();
        chk("t3 frame_count", 32'(bus_main.frame_count), 32'd2);

        // odd byte count on a line
        frame_open();
        base_pv = pv_cnt;
        line_begin();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE);
        line_end();
        chk("t2 lerr", 32'(bus_main.line_error), 32'h1);
        chk("t2 pulses", 32'(pv_cnt - base_pv), 32'd2);
        chk("t2 px0", 32'(pix_log[base_pv%64]), 32'hAABB);
        chk("t2 px1", 32'(pix_log[(base_pv+1)%64]), 32'hCCDD);
        chk("t2 x1", 32'(x_log[(base_pv+1)%64]), 32'd1);
        line_begin();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        line_end();
        chk("t2 pulses2", 32'(pv_cnt - base_pv), 32'd4);
        chk("t2 px2", 32'(pix_log[(base_pv+2)%64]), 32'h0102);
        chk("t2 x2", 32'(x_log[(base_pv+2)%64]), 32'd0);
        chk("t2 y2", 32'(y_log[(base_pv+2)%64]), 32'd1);
        chk("t2 px3", 32'(pix_log[(base_pv+3)%64]), 32'h0304);
        frame_close();
        chk("t2 frame_count", 32'(bus_main.frame_count), 32'd3);

        // reset in the middle of line 1
        frame_open();
        line_begin();
        for (int k = 0; k < 6; k++) send_byte(8'(8'h10 + k));
        line_end();
        line_begin();
        for (int k = 0; k < 5; k++) send_byte(8'(8'h20 + k));
        reset = 1'b1;
        tick(1);
        chk_all_zero("t4 reset");
        reset = 1'b0;
        base_pv = pv_cnt;
        base_fd = fd_cnt;
        for (int k = 5; k < 8; k++) send_byte(8'(8'h20 + k));
        line_end();
        line_begin();
        for (int k = 0; k < 4; k++) send_byte(8'(8'h30 + k));
        line_end();
        chk("t4 no pulses", 32'(pv_cnt - base_pv), 32'd0);
        frame_close();
        chk("t4 no done", 32'(fd_cnt - base_fd), 32'd0);

        // vsync rise coincides with a LO-byte pclk edge
        vsync = 1'b0;
        tick(8);
        base_pv = pv_cnt;
        base_fd = fd_cnt;
        line_begin();
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        data = 8'h88;
        pclk = 1'b0;
        tick(4);
        pclk  = 1'b1;
        vsync = 1'b1;
        tick(8);
        href = 1'b0;
        tick(8);
        chk("t5 pulses", 32'(pv_cnt - base_pv), 32'd1);
        chk("t5 pixel", 32'(bus_main.camera_pixel), 32'h5566);
        chk("t5 done", 32'(fd_cnt - base_fd), 32'd1);
        chk("t5 frame_count", 32'(bus_main.frame_count), 32'd1);

        // 256 single-pixel frames, then an empty one
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        chk("t6 count after reset", 32'(bus_main.frame_count), 32'd0);
        base_pv = pv_cnt;
        base_fd = fd_cnt;
        for (int f = 0; f < 256; f++) begin
            vsync = 1'b0;
            tick(6);
            href = 1'b1;
            tick(2);
            send_byte(8'(f));
            send_byte(~8'(f));
            href = 1'b0;
            tick(2);
            vsync = 1'b1;
            tick(6);
            if (f == 254) chk("t6 count 255", 32'(bus_main.frame_count), 32'd255);
        end
        chk("t6 done pulses", 32'(fd_cnt - base_fd), 32'd256);
        chk("t6 pixel pulses", 32'(pv_cnt - base_pv), 32'd256);
        chk("t6 wrap", 32'(bus_main.frame_count), 32'd0);
        chk("t6 last pixel", 32'(bus_main.camera_pixel), 32'hFF00);
        vsync = 1'b0;
        tick(8);
        vsync = 1'b1;
        tick(10);
        chk("t6 empty frame", 32'(fd_cnt - base_fd), 32'd256);
        chk("t6 empty count", 32'(bus_main.frame_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
